// File: rtl/trap_ctrl_pkg.sv
// rtl/trap_ctrl_pkg.sv - CSR addresses, cause codes and mstatus/mie bit indices for trap_ctrl
package trap_ctrl_pkg;

    localparam int XLEN   = 32;
    localparam int CSR_AW = 12;

    localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
    localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
    localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;

    localparam logic [XLEN-1:0] CAUSE_MSI   = 32'h8000_0003;
    localparam logic [XLEN-1:0] CAUSE_MTI   = 32'h8000_0007;
    localparam logic [XLEN-1:0] CAUSE_ECALL = 32'h0000_000B;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MIE_MSIE       = 3;
    localparam int MIE_MTIE       = 7;

endpackage

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - M-mode trap/mret sequencer; TRAP_VECTORED_EN enables vectored mtvec
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int CSR_ADDR_W = CSR_AW
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  timer_irq_i,
    input  logic                  software_irq_i,
    input  logic                  inst_valid_i,
    input  logic [DATA_WIDTH-1:0] inst_addr_i,
    input  logic                  ecall_i,
    input  logic                  mret_i,
    input  logic [DATA_WIDTH-1:0] csr_mstatus_i,
    input  logic [DATA_WIDTH-1:0] csr_mie_i,
    input  logic [DATA_WIDTH-1:0] csr_mtvec_i,
    input  logic [DATA_WIDTH-1:0] csr_mepc_i,
    output logic                  csr_we_o,
    output logic [CSR_ADDR_W-1:0] csr_waddr_o,
    output logic [DATA_WIDTH-1:0] csr_wdata_o,
    output logic                  hold_o,
    output logic                  jump_o,
    output logic [DATA_WIDTH-1:0] jump_addr_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEPC,
        S_MCAUSE,
        S_MSTATUS,
        S_MRET,
        S_JUMP
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] cause_q;
    logic [DATA_WIDTH-1:0] mstatus_q;
    logic                  hold_q;

    logic                  take_msi;
    logic                  take_mti;
    logic                  take_ecall;
    logic                  take_trap;
    logic                  take_mret;
    logic                  detect;
    logic [DATA_WIDTH-1:0] take_cause;
    logic                  unused_bits;

    // Entering a trap: save MIE into MPIE, mask interrupts, return privilege M
    function automatic logic [DATA_WIDTH-1:0] trap_mstatus(input logic [DATA_WIDTH-1:0] m);
        logic [DATA_WIDTH-1:0] r;
        r = m;
        r[MSTATUS_MPIE] = m[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    // Returning: restore MIE from MPIE and set MPIE
    function automatic logic [DATA_WIDTH-1:0] mret_mstatus(input logic [DATA_WIDTH-1:0] m);
        logic [DATA_WIDTH-1:0] r;
        r = m;
        r[MSTATUS_MIE]  = m[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        return r;
    endfunction

    // Handler address; vectored mode only for interrupts
    function automatic logic [DATA_WIDTH-1:0] trap_target(input logic [DATA_WIDTH-1:0] tvec,
                                                         input logic [DATA_WIDTH-1:0] cause);
        logic [DATA_WIDTH-1:0] base;
        base = {tvec[DATA_WIDTH-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
        if (tvec[1:0] == 2'b01 && cause[DATA_WIDTH-1]) begin
            base = base + {{(DATA_WIDTH-7){1'b0}}, cause[4:0], 2'b00};
        end
`else
        if (cause[0] == 1'b0 && cause[0] == 1'b1) begin
            base = '0;
        end
`endif
        return base;
    endfunction

    // Take decision in priority order MSI > MTI > ecall > mret; bubbles never take
    always_comb begin
        take_msi   = inst_valid_i & csr_mstatus_i[MSTATUS_MIE] & csr_mie_i[MIE_MSIE] & software_irq_i;
        take_mti   = inst_valid_i & csr_mstatus_i[MSTATUS_MIE] & csr_mie_i[MIE_MTIE] & timer_irq_i;
        take_ecall = inst_valid_i & ecall_i;
        take_trap  = take_msi | take_mti | take_ecall;
        take_mret  = inst_valid_i & mret_i & ~take_trap;
        detect     = (state == S_IDLE) & ~rst_i & (take_trap | take_mret);
        if (take_msi) begin
            take_cause = CAUSE_MSI;
        end else if (take_mti) begin
            take_cause = CAUSE_MTI;
        end else begin
            take_cause = CAUSE_ECALL;
        end
    end

    assign hold_o      = hold_q | detect;
    assign unused_bits = ^{csr_mie_i, csr_mtvec_i[1:0]};

    // Sequencer: one CSR write per cycle, outputs registered alongside the state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            cause_q     <= '0;
            mstatus_q   <= '0;
            hold_q      <= 1'b0;
            csr_we_o    <= 1'b0;
            csr_waddr_o <= '0;
            csr_wdata_o <= '0;
            jump_o      <= 1'b0;
            jump_addr_o <= '0;
        end else begin
            hold_q      <= 1'b0;
            csr_we_o    <= 1'b0;
            csr_waddr_o <= '0;
            csr_wdata_o <= '0;
            jump_o      <= 1'b0;
            jump_addr_o <= '0;
            case (state)
                S_IDLE: begin
                    if (detect) begin
                        cause_q   <= take_cause;
                        mstatus_q <= csr_mstatus_i;
                        hold_q    <= 1'b1;
                        csr_we_o  <= 1'b1;
                        if (take_trap) begin
                            state       <= S_MEPC;
                            csr_waddr_o <= CSR_ADDR_W'(CSR_MEPC);
                            csr_wdata_o <= inst_addr_i;
                        end else begin
                            state       <= S_MRET;
                            csr_waddr_o <= CSR_ADDR_W'(CSR_MSTATUS);
                            csr_wdata_o <= mret_mstatus(csr_mstatus_i);
                        end
                    end
                end
                S_MEPC: begin
                    state       <= S_MCAUSE;
                    hold_q      <= 1'b1;
                    csr_we_o    <= 1'b1;
                    csr_waddr_o <= CSR_ADDR_W'(CSR_MCAUSE);
                    csr_wdata_o <= cause_q;
                end
                S_MCAUSE: begin
                    state       <= S_MSTATUS;
                    hold_q      <= 1'b1;
                    csr_we_o    <= 1'b1;
                    csr_waddr_o <= CSR_ADDR_W'(CSR_MSTATUS);
                    csr_wdata_o <= trap_mstatus(mstatus_q);
                end
                S_MSTATUS: begin
                    state       <= S_JUMP;
                    jump_o      <= 1'b1;
                    jump_addr_o <= trap_target(csr_mtvec_i, cause_q);
                end
                S_MRET: begin
                    state       <= S_JUMP;
                    jump_o      <= 1'b1;
                    jump_addr_o <= csr_mepc_i;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
